rca_byte_seq: RTL and testbench

RCA_BYTE_SEQ -- requirements
Module: rca_byte_seq

---
 rtl/rca_byte_seq.sv | 171 +++++++++++++++++
 tb/tb_rca_byte_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_byte_seq.sv
// rca_byte_seq
//   Byte-serial operand sequencer and result collector for an external
//   8-bit ripple adder. A W-bit (W = 8*NBYTES) add is broken into NBYTES
//   byte steps; each step presents one byte of each operand plus the
//   running carry to the adder. It then captures the 9-bit sum and chains
//   the adder's carry-out into the next step.
//
// Parameters
//   NBYTES   number of operand bytes (>= 2), W = 8*NBYTES
//
// Ports
//   CLK      in   1     sole clock, rising edge
//   RST      in   1     asynchronous, active-high reset
//   IN_VLD   in   1     operand request valid
//   IN_RDY   out  1     block can accept operands (IDLE only)
//   A, B     in   W     operands
//   C        in   1     initial carry-in
//   SUB      in   1     subtract request (only with RCA_SUB_EN)
//   OUT_VLD  out  1     result valid (DONE only)
//   OUT_RDY  in   1     consumer accepts result
//   S        out  W+1   result, carry-out in MSB
//   ADD_A    out  8     operand A byte to the adder
//   ADD_B    out  8     operand B byte to the adder
//   ADD_C    out  1     carry to the adder
//   ADD_S    in   9     adder sum, ADD_S[8] = carry-out
//
// Configuration
//   RCA_SUB_EN  when defined, adds port SUB. With SUB=1 the B bytes are
//               inverted and the initial carry is forced to 1, so that
//               S = A - B mod 2^W and S[W] = 1 means "no borrow".

module rca_byte_seq #(
  parameter int NBYTES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VLD,
  output logic                IN_RDY,
  input  logic [8*NBYTES-1:0] A,
  input  logic [8*NBYTES-1:0] B,
  input  logic                C,
`ifdef RCA_SUB_EN
  input  logic                SUB,
`endif
  output logic                OUT_VLD,
  input  logic                OUT_RDY,
  output logic [8*NBYTES:0]   S,
  output logic [7:0]          ADD_A,
  output logic [7:0]          ADD_B,
  output logic                ADD_C,
  input  logic [8:0]          ADD_S
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W:0]      s_q;
  logic            inRdy_q;
  logic            outVld_q;
`ifdef RCA_SUB_EN
  logic            sub_q;
`endif

  // Bit offset of the current byte: k*8, built by concatenation so the
  // select index needs no multiplier and has no width surprises.
  logic [KW+2:0]   bitOff;
  assign bitOff = {k_q, 3'b000};

  assign IN_RDY  = inRdy_q;
  assign OUT_VLD = outVld_q;
  assign S       = s_q;

  // Adder operand mux. This has to be combinational from the registers,
  // because the adder's sum for byte k is captured on the same edge.
  // Outside RUN the adder inputs are parked at zero.
  always_comb begin
    ADD_A = 8'h00;
    ADD_B = 8'h00;
    ADD_C = 1'b0;
    if (state_q == RUN) begin
      ADD_A = a_q[bitOff +: 8];
`ifdef RCA_SUB_EN
      ADD_B = sub_q ? ~b_q[bitOff +: 8] : b_q[bitOff +: 8];
`else
      ADD_B = b_q[bitOff +: 8];
`endif
      ADD_C = carry_q;
    end
  end

  // Sequencer FSM: accepts operands in IDLE and walks the bytes in RUN.
  // It then holds the result in DONE until the consumer takes it.
  // IN_RDY and OUT_VLD are kept as their own flops so that they change
  // together with the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      inRdy_q  <= 1'b1;
      outVld_q <= 1'b0;
`ifdef RCA_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VLD) begin
            a_q     <= A;
            b_q     <= B;
            s_q     <= '0;
            k_q     <= '0;
            inRdy_q <= 1'b0;
            state_q <= RUN;
`ifdef RCA_SUB_EN
            sub_q   <= SUB;
            // Two's-complement subtract: invert B and add one through
            // the initial carry. In this case the caller's C is ignored.
            carry_q <= SUB ? 1'b1 : C;
`else
            carry_q <= C;
`endif
          end
        end

        RUN: begin
          s_q[bitOff +: 8] <= ADD_S[7:0];
          carry_q          <= ADD_S[8];
          if (k_q == KW'(NBYTES - 1)) begin
            // The final carry-out becomes the MSB of the wide result.
            s_q[W]   <= ADD_S[8];
            k_q      <= '0;
            outVld_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        DONE: begin
          if (OUT_RDY) begin
            outVld_q <= 1'b0;
            inRdy_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end

        default: begin
          outVld_q <= 1'b0;
          inRdy_q  <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_byte_seq.sv
// tb_rca_byte_seq
//   Self-checking bench for rca_byte_seq. The bench models the external
//   8-bit ripple adder as a combinational sum of the adder byte buses.
//   Expected wide results are pushed to a scoreboard queue when operands
//   are offered. They are popped and compared when the block presents a
//   result. Define RCA_SUB_EN to also cover the subtract option.

module tb_rca_byte_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          CLK;
  logic          RST;
  logic          IN_VLD;
  logic          IN_RDY;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          C;
`ifdef RCA_SUB_EN
  logic          SUB;
`endif
  logic          OUT_VLD;
  logic          OUT_RDY;
  logic [W:0]    S;
  logic [7:0]    ADD_A;
  logic [7:0]    ADD_B;
  logic          ADD_C;
  logic [8:0]    ADD_S;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W:0]   s;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  logic [W:0]    sb[$];
  vec_t          vecs[$];

  rca_byte_seq #(.NBYTES(NBYTES)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN_VLD  (IN_VLD),
    .IN_RDY  (IN_RDY),
    .A       (A),
    .B       (B),
    .C       (C),
`ifdef RCA_SUB_EN
    .SUB     (SUB),
`endif
    .OUT_VLD (OUT_VLD),
    .OUT_RDY (OUT_RDY),
    .S       (S),
    .ADD_A   (ADD_A),
    .ADD_B   (ADD_B),
    .ADD_C   (ADD_C),
    .ADD_S   (ADD_S)
  );

  // This models the external ripple adder: a purely combinational 8-bit
  // add that produces a carry-out.
  assign ADD_S = {1'b0, ADD_A} + {1'b0, ADD_B} + {8'h00, ADD_C};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit, so that a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model of the wide add or subtract.
  function automatic logic [W:0] modelSum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic sub);
    logic [W:0] r;
    if (sub)
      r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else
      r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // This task starts at a negedge, offers one operand set, and returns at
  // the negedge just after the accept edge (byte index 0).
  task automatic applyStimulus(input vec_t v);
    int n;
    n = 0;
    while (!IN_RDY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkVal("accept_ready", 64'(IN_RDY), 64'(1));
    A      = v.a;
    B      = v.b;
    C      = v.c;
`ifdef RCA_SUB_EN
    SUB    = v.sub;
`endif
    IN_VLD = 1'b1;
    sb.push_back(v.s);
    @(posedge CLK);
    @(negedge CLK);
    IN_VLD = 1'b0;
  endtask

  // This task waits (bounded) for OUT_VLD and checks the edge count
  // against edgesLeft. It compares S with the scoreboard head. Optionally,
  // it holds OUT_RDY low for holdCycles and checks that the result is held.
  // It then checks that the block is back in IDLE one edge after it is
  // released.
  task automatic checkOutput(input int edgesLeft, input int holdCycles);
    int         lat;
    logic [W:0] exp;
    lat     = 0;
    OUT_RDY = (holdCycles == 0);
    while (!OUT_VLD && lat < 4 * NBYTES + 8) begin
      @(negedge CLK);
      lat++;
    end
    checkVal("latency", 64'(lat), 64'(edgesLeft));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got result 0x%0h, expected none", S);
      OUT_RDY = 1'b1;
      return;
    end
    exp = sb.pop_front();
    if (!OUT_VLD) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: got OUT_VLD=0, expected 1");
      OUT_RDY = 1'b1;
      return;
    end
    checkVal("result", 64'(S), 64'(exp));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge CLK);
      checkVal("hold_vld", 64'(OUT_VLD), 64'(1));
      checkVal("hold_s", 64'(S), 64'(exp));
      checkVal("hold_in_rdy", 64'(IN_RDY), 64'(0));
    end
    OUT_RDY = 1'b1;
    @(negedge CLK);
    checkVal("release_vld", 64'(OUT_VLD), 64'(0));
    checkVal("release_rdy", 64'(IN_RDY), 64'(1));
  endtask

  initial begin
    vec_t       v;
    logic [W:0] exp;
    int         accepts;
    int         results;
    int         cyc;
    int         lastCyc;

    RST     = 1'b1;
    IN_VLD  = 1'b0;
    A       = '0;
    B       = '0;
    C       = 1'b0;
    OUT_RDY = 1'b1;
`ifdef RCA_SUB_EN
    SUB     = 1'b0;
`endif

    // Reset values, checked before any clock edge.
    #3;
    checkVal("rst_in_rdy", 64'(IN_RDY), 64'(1));
    checkVal("rst_out_vld", 64'(OUT_VLD), 64'(0));
    checkVal("rst_s", 64'(S), 64'(0));
    checkVal("rst_add_a", 64'(ADD_A), 64'(0));
    checkVal("rst_add_b", 64'(ADD_B), 64'(0));
    checkVal("rst_add_c", 64'(ADD_C), 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // 0xFF + 0x01: the carry out of byte 0 must feed byte 1.
    v = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100};
    applyStimulus(v);
    checkVal("k0_add_a", 64'(ADD_A), 64'(8'hFF));
    checkVal("k0_add_b", 64'(ADD_B), 64'(8'h01));
    checkVal("k0_add_c", 64'(ADD_C), 64'(0));
    checkVal("run_in_rdy", 64'(IN_RDY), 64'(0));
    checkVal("run_out_vld", 64'(OUT_VLD), 64'(0));
    @(negedge CLK);
    checkVal("k1_add_a", 64'(ADD_A), 64'(8'h00));
    checkVal("k1_add_b", 64'(ADD_B), 64'(8'h00));
    checkVal("k1_add_c", 64'(ADD_C), 64'(1));
    checkOutput(NBYTES - 1, 0);
    checkVal("idle_add_a", 64'(ADD_A), 64'(0));

    // Vector table. Index 2 also exercises a 3-cycle consumer stall.
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000});
    vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 33'h0_2345_678A});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 33'h0_0000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000});
    vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 33'h0_0100_0100});
    vecs.push_back('{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 33'h0_DFD1_0456});
`ifdef RCA_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 33'h1_0000_0002});
    vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 33'h0_FFFF_FFFE});
    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 33'h1_0000_0002});
`endif
    for (int i = 0; i < 4; i++) begin
      v.a   = $urandom;
      v.b   = $urandom;
      v.c   = 1'($urandom_range(0, 1));
      v.sub = 1'b0;
      v.s   = modelSum(v.a, v.b, v.c, v.sub);
      vecs.push_back(v);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(NBYTES, (i == 2) ? 3 : 0);
    end

    // Reset in the middle of an operation, at byte index 2.
    v.a = 32'hA5A5_A5A5;
    v.b = 32'h5A5A_5A5A;
    v.c = 1'b1;
    v.sub = 1'b0;
    v.s = modelSum(v.a, v.b, v.c, v.sub);
    applyStimulus(v);
    @(negedge CLK);
    @(negedge CLK);
    checkVal("k2_add_a", 64'(ADD_A), 64'(8'hA5));
    #2 RST = 1'b1;
    #1;
    checkVal("abort_in_rdy", 64'(IN_RDY), 64'(1));
    checkVal("abort_out_vld", 64'(OUT_VLD), 64'(0));
    checkVal("abort_s", 64'(S), 64'(0));
    checkVal("abort_add_a", 64'(ADD_A), 64'(0));
    checkVal("abort_add_c", 64'(ADD_C), 64'(0));
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    v = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0002};
    applyStimulus(v);
    checkOutput(NBYTES, 0);

    // IN_VLD is held high continuously. Expect one accept per IDLE visit
    // and results spaced NBYTES+2 cycles apart.
    A       = 32'h0101_0101;
    B       = 32'h0202_0202;
    C       = 1'b0;
`ifdef RCA_SUB_EN
    SUB     = 1'b0;
`endif
    OUT_RDY = 1'b1;
    IN_VLD  = 1'b1;
    accepts = 0;
    results = 0;
    cyc     = 0;
    lastCyc = -1;
    while (results < 3 && cyc < 100) begin
      if (IN_RDY) begin
        accepts++;
        sb.push_back(33'h0_0303_0303);
      end
      if (OUT_VLD) begin
        results++;
        exp = (sb.size() != 0) ? sb.pop_front() : '1;
        checkVal("stream_result", 64'(S), 64'(exp));
        if (lastCyc >= 0)
          checkVal("stream_spacing", 64'(cyc - lastCyc), 64'(NBYTES + 2));
        lastCyc = cyc;
        if (results == 3)
          IN_VLD = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    IN_VLD = 1'b0;
    checkVal("stream_results", 64'(results), 64'(3));
    checkVal("stream_accepts", 64'(accepts), 64'(3));
    checkVal("stream_idle", 64'(IN_RDY), 64'(1));
    checkVal("stream_sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
